// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB maintenance controller: op encodings,
// entry/ELO layouts and the helper that builds a write entry.
package tlb_pkg;

    localparam logic [2:0] TLBOP_SRCH = 3'd0;
    localparam logic [2:0] TLBOP_RD   = 3'd1;
    localparam logic [2:0] TLBOP_WR   = 3'd2;
    localparam logic [2:0] TLBOP_FILL = 3'd3;
    localparam logic [2:0] TLBOP_INV  = 3'd4;

    localparam int ELO_W  = 27;
    localparam int TLBE_W = 89;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd22;

    // Bit offsets (LSB) of each field inside the packed TLB entry.
    localparam int TLBE_V1_LSB   = 0;
    localparam int TLBE_D1_LSB   = 1;
    localparam int TLBE_MAT1_LSB = 2;
    localparam int TLBE_PLV1_LSB = 4;
    localparam int TLBE_PPN1_LSB = 6;
    localparam int TLBE_V0_LSB   = 26;
    localparam int TLBE_D0_LSB   = 27;
    localparam int TLBE_MAT0_LSB = 28;
    localparam int TLBE_PLV0_LSB = 30;
    localparam int TLBE_PPN0_LSB = 32;
    localparam int TLBE_G_LSB    = 52;
    localparam int TLBE_ASID_LSB = 53;
    localparam int TLBE_PS_LSB   = 63;
    localparam int TLBE_VPPN_LSB = 69;
    localparam int TLBE_E_LSB    = 88;

    // TLBELO layout: {ppn, g, mat, plv, d, v}
    typedef struct packed {
        logic [19:0] ppn;
        logic        g;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        d;
        logic        v;
    } elo_t;

    // Packed TLB entry, field order matches the offsets above.
    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlbe_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Build the entry written by TLBWR/TLBFILL; global only if both pages are global.
    function automatic tlbe_t make_entry(input logic             e,
                                         input logic [18:0]      vppn,
                                         input logic [5:0]       ps,
                                         input logic [9:0]       asid,
                                         input logic [ELO_W-1:0] elo0_raw,
                                         input logic [ELO_W-1:0] elo1_raw);
        elo_t  elo0;
        elo_t  elo1;
        tlbe_t ent;
        elo0      = elo_t'(elo0_raw);
        elo1      = elo_t'(elo1_raw);
        ent.e     = e;
        ent.vppn  = vppn;
        ent.ps    = ps;
        ent.asid  = asid;
        ent.g     = elo0.g & elo1.g;
        ent.ppn0  = elo0.ppn;
        ent.plv0  = elo0.plv;
        ent.mat0  = elo0.mat;
        ent.d0    = elo0.d;
        ent.v0    = elo0.v;
        ent.ppn1  = elo1.ppn;
        ent.plv1  = elo1.plv;
        ent.mat1  = elo1.mat;
        ent.d1    = elo1.d;
        ent.v1    = elo1.v;
        return ent;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request/response bus between the CSR block and the TLB op controller.
interface tlb_op_ctrl_if #(
    parameter int IDXW = 4
);
    import tlb_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [4:0]        inv_op;
    logic [9:0]        inv_asid;
    logic [18:0]       inv_vppn;
    logic [9:0]        csr_asid;
    logic [18:0]       csr_vppn;
    logic [IDXW-1:0]   csr_index;
    logic [5:0]        csr_ps;
    logic              csr_ne;
    logic              csr_refill;
    logic [ELO_W-1:0]  csr_elo0;
    logic [ELO_W-1:0]  csr_elo1;
    logic              done;
    logic [2:0]        done_code;
    logic              res_found;
    logic [IDXW-1:0]   res_index;
    logic              res_ine;
    logic [TLBE_W-1:0] res_entry;

    // CSR side issues ops and reads results
    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_asid, csr_vppn, csr_index, csr_ps, csr_ne, csr_refill,
               csr_elo0, csr_elo1,
        input  op_ready, done, done_code, res_found, res_index, res_ine, res_entry
    );

    // Controller side
    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_asid, csr_vppn, csr_index, csr_ps, csr_ne, csr_refill,
               csr_elo0, csr_elo1,
        output op_ready, done, done_code, res_found, res_index, res_ine, res_entry
    );

endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLB maintenance ops (SRCH/RD/WR/FILL/INV) through IDLE->EXEC->DONE,
// shares TLB search port 1 with the load/store stage and picks FILL indices
// from a free-running counter.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    tlb_op_ctrl_if.slave      op_if,
    input  logic              mem_req,
    input  logic [18:0]       mem_vppn,
    input  logic              mem_bit12,
    input  logic [9:0]        mem_asid,
    output logic              mem_grant,
    output logic [18:0]       tlb_s1_vppn,
    output logic              tlb_s1_bit12,
    output logic [9:0]        tlb_s1_asid,
    input  logic              tlb_s1_found,
    input  logic [IDXW-1:0]   tlb_s1_index,
    output logic              tlb_invtlb_valid,
    output logic [4:0]        tlb_invtlb_op,
    output logic              tlb_we,
    output logic [IDXW-1:0]   tlb_w_index,
    output logic [TLBE_W-1:0] tlb_w_entry,
    output logic [IDXW-1:0]   tlb_r_index,
    input  logic [TLBE_W-1:0] tlb_r_entry
);

    state_e            state_q, state_d;
    logic [2:0]        op_code_q;
    logic [4:0]        inv_op_q;
    logic [9:0]        inv_asid_q;
    logic [18:0]       inv_vppn_q;
    logic [9:0]        csr_asid_q;
    logic [18:0]       csr_vppn_q;
    logic [IDXW-1:0]   csr_index_q;
    logic [5:0]        csr_ps_q;
    logic              csr_ne_q;
    logic              csr_refill_q;
    logic [ELO_W-1:0]  csr_elo0_q;
    logic [ELO_W-1:0]  csr_elo1_q;
    logic [IDXW-1:0]   fill_idx_q;
    logic [IDXW-1:0]   fill_cnt_q, fill_cnt_d;
    logic              res_found_q;
    logic [IDXW-1:0]   res_index_q;
    logic              res_ine_q;
    logic [TLBE_W-1:0] res_entry_q;

    logic       accept;
    logic       in_exec;
    logic       is_srch, is_rd, is_wr, is_fill, is_inv, is_rsvd;
    logic       inv_op_ok;
    logic       port1_busy;
    logic [18:0] op_s1_vppn;
    logic [9:0]  op_s1_asid;
    tlbe_t      w_entry;
    tlbe_t      r_entry;

    assign accept    = op_if.op_valid && (state_q == S_IDLE);
    assign in_exec   = (state_q == S_EXEC);
    assign is_srch   = (op_code_q == TLBOP_SRCH);
    assign is_rd     = (op_code_q == TLBOP_RD);
    assign is_wr     = (op_code_q == TLBOP_WR);
    assign is_fill   = (op_code_q == TLBOP_FILL);
    assign is_inv    = (op_code_q == TLBOP_INV);
    assign is_rsvd   = (op_code_q > TLBOP_INV);
    assign inv_op_ok = (inv_op_q <= 5'd6);

    // Port 1 is taken from load/store only while a SRCH/INV is executing.
    assign port1_busy = in_exec && (is_srch || is_inv);
    assign op_s1_vppn = is_inv ? inv_vppn_q : csr_vppn_q;
    assign op_s1_asid = is_inv ? inv_asid_q : csr_asid_q;
    assign w_entry    = make_entry(csr_refill_q | ~csr_ne_q, csr_vppn_q, csr_ps_q,
                                   csr_asid_q, csr_elo0_q, csr_elo1_q);
    assign r_entry    = tlbe_t'(tlb_r_entry);

    assign fill_cnt_d = (fill_cnt_q == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: EXEC and DONE each last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (op_if.op_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: handshake, TLB control and port-1 mux
    always_comb begin
        op_if.op_ready   = (state_q == S_IDLE);
        op_if.done       = (state_q == S_DONE);
        op_if.done_code  = op_code_q;
        tlb_we           = 1'b0;
        tlb_w_index      = '0;
        tlb_w_entry      = '0;
        tlb_r_index      = '0;
        tlb_invtlb_valid = 1'b0;
        tlb_invtlb_op    = '0;
        mem_grant        = mem_req & ~port1_busy;
        if (in_exec && (is_wr || is_fill)) begin
            tlb_we      = 1'b1;
            tlb_w_index = is_fill ? fill_idx_q : csr_index_q;
            tlb_w_entry = w_entry;
        end
        if (in_exec && is_rd) begin
            tlb_r_index = csr_index_q;
        end
        if (in_exec && is_inv) begin
            tlb_invtlb_valid = inv_op_ok;
            tlb_invtlb_op    = inv_op_q;
        end
        if (mem_grant) begin
            tlb_s1_vppn  = mem_vppn;
            tlb_s1_bit12 = mem_bit12;
            tlb_s1_asid  = mem_asid;
        end else begin
            tlb_s1_vppn  = op_s1_vppn;
            tlb_s1_bit12 = 1'b0;
            tlb_s1_asid  = op_s1_asid;
        end
    end

    // Latch the op and its CSR snapshot at accept; fill counter runs freely
    always_ff @(posedge clk) begin
        if (reset) begin
            op_code_q    <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_vppn_q   <= '0;
            csr_asid_q   <= '0;
            csr_vppn_q   <= '0;
            csr_index_q  <= '0;
            csr_ps_q     <= '0;
            csr_ne_q     <= 1'b0;
            csr_refill_q <= 1'b0;
            csr_elo0_q   <= '0;
            csr_elo1_q   <= '0;
            fill_idx_q   <= '0;
            fill_cnt_q   <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            if (accept) begin
                op_code_q    <= op_if.op_code;
                inv_op_q     <= op_if.inv_op;
                inv_asid_q   <= op_if.inv_asid;
                inv_vppn_q   <= op_if.inv_vppn;
                csr_asid_q   <= op_if.csr_asid;
                csr_vppn_q   <= op_if.csr_vppn;
                csr_index_q  <= op_if.csr_index;
                csr_ps_q     <= op_if.csr_ps;
                csr_ne_q     <= op_if.csr_ne;
                csr_refill_q <= op_if.csr_refill;
                csr_elo0_q   <= op_if.csr_elo0;
                csr_elo1_q   <= op_if.csr_elo1;
                fill_idx_q   <= fill_cnt_q;
            end
        end
    end

    // Capture results at the end of EXEC; they stay until the next op's EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            res_found_q <= 1'b0;
            res_index_q <= '0;
            res_ine_q   <= 1'b0;
            res_entry_q <= '0;
        end else if (in_exec) begin
            res_ine_q <= is_rsvd | (is_inv & ~inv_op_ok);
            if (is_srch) begin
                res_found_q <= tlb_s1_found;
                res_index_q <= tlb_s1_index;
            end
            if (is_rd) begin
                // An invalid entry reads back as all zeros
                res_entry_q <= r_entry.e ? tlb_r_entry : '0;
            end
        end
    end

    assign op_if.res_found = res_found_q;
    assign op_if.res_index = res_index_q;
    assign op_if.res_ine   = res_ine_q;
    assign op_if.res_entry = res_entry_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural 16-entry TLB.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_req;
    logic [18:0]       mem_vppn;
    logic              mem_bit12;
    logic [9:0]        mem_asid;
    logic              mem_grant;
    logic [18:0]       tlb_s1_vppn;
    logic              tlb_s1_bit12;
    logic [9:0]        tlb_s1_asid;
    logic              tlb_s1_found;
    logic [IDXW-1:0]   tlb_s1_index;
    logic              tlb_invtlb_valid;
    logic [4:0]        tlb_invtlb_op;
    logic              tlb_we;
    logic [IDXW-1:0]   tlb_w_index;
    logic [TLBE_W-1:0] tlb_w_entry;
    logic [IDXW-1:0]   tlb_r_index;
    logic [TLBE_W-1:0] tlb_r_entry;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tlb_op_ctrl_if #(.IDXW(IDXW)) op_if ();

    tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk              (clk),
        .reset            (reset),
        .op_if            (op_if.slave),
        .mem_req          (mem_req),
        .mem_vppn         (mem_vppn),
        .mem_bit12        (mem_bit12),
        .mem_asid         (mem_asid),
        .mem_grant        (mem_grant),
        .tlb_s1_vppn      (tlb_s1_vppn),
        .tlb_s1_bit12     (tlb_s1_bit12),
        .tlb_s1_asid      (tlb_s1_asid),
        .tlb_s1_found     (tlb_s1_found),
        .tlb_s1_index     (tlb_s1_index),
        .tlb_invtlb_valid (tlb_invtlb_valid),
        .tlb_invtlb_op    (tlb_invtlb_op),
        .tlb_we           (tlb_we),
        .tlb_w_index      (tlb_w_index),
        .tlb_w_entry      (tlb_w_entry),
        .tlb_r_index      (tlb_r_index),
        .tlb_r_entry      (tlb_r_entry)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural TLB ----------------
    tlbe_t tlb_mem [TLBNUM];
    logic  tlb_seeded = 1'b0;

    function automatic logic vmatch(input tlbe_t t, input logic [18:0] v);
        return (t.ps == PS_4M) ? (t.vppn[18:9] == v[18:9]) : (t.vppn == v);
    endfunction

    // Combinational search and read
    always_comb begin
        tlb_s1_found = 1'b0;
        tlb_s1_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tlb_mem[i].e && (tlb_mem[i].g || tlb_mem[i].asid == tlb_s1_asid)
                && vmatch(tlb_mem[i], tlb_s1_vppn)) begin
                tlb_s1_found = 1'b1;
                tlb_s1_index = IDXW'(i);
            end
        end
        tlb_r_entry = tlb_mem[tlb_r_index];
    end

    // Seed once, then clocked write / invalidate
    always @(posedge clk) begin
        if (!tlb_seeded) begin
            for (int i = 0; i < TLBNUM; i++) tlb_mem[i] <= '0;
            tlb_mem[7]  <= tlbe_t'({1'b0, {88{1'b1}}});
            tlb_seeded  <= 1'b1;
        end else begin
            if (tlb_we) tlb_mem[tlb_w_index] <= tlbe_t'(tlb_w_entry);
            if (tlb_invtlb_valid) begin
                for (int i = 0; i < TLBNUM; i++) begin
                    logic hit;
                    case (tlb_invtlb_op)
                        5'd0, 5'd1: hit = 1'b1;
                        5'd2:       hit = tlb_mem[i].g;
                        5'd3:       hit = !tlb_mem[i].g;
                        5'd4:       hit = !tlb_mem[i].g && tlb_mem[i].asid == tlb_s1_asid;
                        5'd5:       hit = !tlb_mem[i].g && tlb_mem[i].asid == tlb_s1_asid
                                          && vmatch(tlb_mem[i], tlb_s1_vppn);
                        5'd6:       hit = (tlb_mem[i].g || tlb_mem[i].asid == tlb_s1_asid)
                                          && vmatch(tlb_mem[i], tlb_s1_vppn);
                        default:    hit = 1'b0;
                    endcase
                    if (hit) tlb_mem[i].e <= 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; cyc mirrors the free-running fill counter value
    task automatic tick();
        @(posedge clk);
        cyc = reset ? 0 : cyc + 1;
        #1;
    endtask

    // Present an op in IDLE; returns in the EXEC cycle
    task automatic issue(input logic [2:0] code);
        op_if.op_code  = code;
        op_if.op_valid = 1'b1;
        chk("op_ready_idle", 128'(op_if.op_ready), 128'(1));
        tick();
        op_if.op_valid = 1'b0;
        chk("done_in_exec", 128'(op_if.done), 128'(0));
        chk("ready_in_exec", 128'(op_if.op_ready), 128'(0));
    endtask

    task automatic to_done(input logic [2:0] code);
        tick();
        chk("done_pulse", 128'(op_if.done), 128'(1));
        chk("done_code", 128'(op_if.done_code), 128'(code));
    endtask

    task automatic to_idle();
        tick();
        chk("done_after", 128'(op_if.done), 128'(0));
    endtask

    tlbe_t exp5;
    tlbe_t wr_ent;
    elo_t  e0, e1;

    initial begin
        reset = 1'b1;
        mem_req = 1'b0; mem_vppn = '0; mem_bit12 = 1'b0; mem_asid = '0;
        op_if.op_valid = 1'b0; op_if.op_code = '0;
        op_if.inv_op = '0; op_if.inv_asid = '0; op_if.inv_vppn = '0;
        op_if.csr_asid = '0; op_if.csr_vppn = '0; op_if.csr_index = '0;
        op_if.csr_ps = '0; op_if.csr_ne = 1'b0; op_if.csr_refill = 1'b0;
        op_if.csr_elo0 = '0; op_if.csr_elo1 = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_op_ready", 128'(op_if.op_ready), 128'(1));
        chk("rst_done", 128'(op_if.done), 128'(0));
        chk("rst_we", 128'(tlb_we), 128'(0));
        chk("rst_inv_valid", 128'(tlb_invtlb_valid), 128'(0));
        chk("rst_res_entry", 128'(op_if.res_entry), 128'(0));
        chk("rst_s1_vppn", 128'(tlb_s1_vppn), 128'(0));
        chk("rst_grant0", 128'(mem_grant), 128'(0));
        mem_req = 1'b1; mem_vppn = 19'h55555; #1;
        chk("rst_grant1", 128'(mem_grant), 128'(1));
        chk("rst_s1_mem", 128'(tlb_s1_vppn), 128'(19'h55555));
        reset = 1'b0; mem_req = 1'b0;

        // ---- WR entry 5 ----
        e0 = '{ppn: 20'h00ABC, g: 1'b0, mat: 2'd1, plv: 2'd3, d: 1'b1, v: 1'b1};
        e1 = '{ppn: 20'h00ABD, g: 1'b1, mat: 2'd1, plv: 2'd0, d: 1'b0, v: 1'b1};
        exp5 = '{e: 1'b1, vppn: 19'h12345, ps: 6'd12, asid: 10'h3, g: 1'b0,
                 ppn0: 20'h00ABC, plv0: 2'd3, mat0: 2'd1, d0: 1'b1, v0: 1'b1,
                 ppn1: 20'h00ABD, plv1: 2'd0, mat1: 2'd1, d1: 1'b0, v1: 1'b1};
        op_if.csr_index = 4'd5; op_if.csr_vppn = 19'h12345; op_if.csr_asid = 10'h3;
        op_if.csr_ps = 6'd12; op_if.csr_ne = 1'b0; op_if.csr_refill = 1'b0;
        op_if.csr_elo0 = e0; op_if.csr_elo1 = e1;
        issue(TLBOP_WR);
        chk("wr_we", 128'(tlb_we), 128'(1));
        chk("wr_index", 128'(tlb_w_index), 128'(5));
        chk("wr_entry", 128'(tlb_w_entry), 128'(exp5));
        to_done(TLBOP_WR);
        to_idle();

        // ---- SRCH hit entry 5, load/store blocked in EXEC ----
        mem_req = 1'b1; mem_vppn = 19'h55555; mem_bit12 = 1'b1; mem_asid = 10'h2AA; #1;
        chk("srch_grant_idle", 128'(mem_grant), 128'(1));
        issue(TLBOP_SRCH);
        chk("srch_grant_exec", 128'(mem_grant), 128'(0));
        chk("srch_s1_vppn", 128'(tlb_s1_vppn), 128'(19'h12345));
        chk("srch_s1_bit12", 128'(tlb_s1_bit12), 128'(0));
        chk("srch_s1_asid", 128'(tlb_s1_asid), 128'(10'h3));
        to_done(TLBOP_SRCH);
        chk("srch_found", 128'(op_if.res_found), 128'(1));
        chk("srch_index", 128'(op_if.res_index), 128'(5));
        chk("srch_grant_done", 128'(mem_grant), 128'(1));
        to_idle();
        mem_req = 1'b0;

        // ---- RD of invalid entry 7 and valid entry 5 ----
        op_if.csr_index = 4'd7;
        issue(TLBOP_RD);
        chk("rd7_r_index", 128'(tlb_r_index), 128'(7));
        to_done(TLBOP_RD);
        chk("rd7_entry", 128'(op_if.res_entry), 128'(0));
        to_idle();
        op_if.csr_index = 4'd5;
        issue(TLBOP_RD);
        to_done(TLBOP_RD);
        chk("rd5_entry", 128'(op_if.res_entry), 128'(exp5));
        to_idle();

        // ---- two FILLs, first at counter 14, second wraps to 1 ----
        e0.g = 1'b1; e1.g = 1'b1;
        op_if.csr_vppn = 19'h00111; op_if.csr_asid = 10'h3; op_if.csr_ps = 6'd22;
        op_if.csr_ne = 1'b1; op_if.csr_refill = 1'b1;
        op_if.csr_elo0 = e0; op_if.csr_elo1 = e1;
        while (cyc % TLBNUM != 14) tick();
        issue(TLBOP_FILL);
        wr_ent = tlbe_t'(tlb_w_entry);
        chk("fill1_index", 128'(tlb_w_index), 128'(14));
        chk("fill1_e", 128'(wr_ent.e), 128'(1));
        chk("fill1_g", 128'(wr_ent.g), 128'(1));
        chk("fill1_ps", 128'(wr_ent.ps), 128'(22));
        to_done(TLBOP_FILL);
        to_idle();
        op_if.csr_refill = 1'b0;
        issue(TLBOP_FILL);
        wr_ent = tlbe_t'(tlb_w_entry);
        chk("fill2_index", 128'(tlb_w_index), 128'(1));
        chk("fill2_e", 128'(wr_ent.e), 128'(0));
        to_done(TLBOP_FILL);
        to_idle();

        // ---- INV op 5 removes entry 5 ----
        mem_req = 1'b1;
        op_if.inv_op = 5'd5; op_if.inv_asid = 10'h3; op_if.inv_vppn = 19'h12345;
        issue(TLBOP_INV);
        chk("inv_grant_exec", 128'(mem_grant), 128'(0));
        chk("inv_valid", 128'(tlb_invtlb_valid), 128'(1));
        chk("inv_op", 128'(tlb_invtlb_op), 128'(5));
        chk("inv_s1_vppn", 128'(tlb_s1_vppn), 128'(19'h12345));
        chk("inv_s1_asid", 128'(tlb_s1_asid), 128'(10'h3));
        chk("inv_we", 128'(tlb_we), 128'(0));
        to_done(TLBOP_INV);
        chk("inv_grant_done", 128'(mem_grant), 128'(1));
        chk("inv_ine", 128'(op_if.res_ine), 128'(0));
        to_idle();
        op_if.csr_vppn = 19'h12345; op_if.csr_asid = 10'h3;
        issue(TLBOP_SRCH);
        to_done(TLBOP_SRCH);
        chk("srch_miss", 128'(op_if.res_found), 128'(0));
        to_idle();

        // ---- INV op 7 and reserved op_code 6 ----
        op_if.inv_op = 5'd7; op_if.inv_vppn = 19'h00111;
        issue(TLBOP_INV);
        chk("inv7_valid", 128'(tlb_invtlb_valid), 128'(0));
        to_done(TLBOP_INV);
        chk("inv7_ine", 128'(op_if.res_ine), 128'(1));
        to_idle();
        issue(3'd6);
        chk("rsvd_we", 128'(tlb_we), 128'(0));
        chk("rsvd_inv_valid", 128'(tlb_invtlb_valid), 128'(0));
        chk("rsvd_grant", 128'(mem_grant), 128'(1));
        to_done(3'd6);
        chk("rsvd_ine", 128'(op_if.res_ine), 128'(1));
        to_idle();
        op_if.csr_vppn = 19'h00111; op_if.csr_asid = 10'h3FF;
        issue(TLBOP_SRCH);
        to_done(TLBOP_SRCH);
        chk("srch14_found", 128'(op_if.res_found), 128'(1));
        chk("srch14_index", 128'(op_if.res_index), 128'(14));
        chk("srch14_ine", 128'(op_if.res_ine), 128'(0));
        to_idle();
        mem_req = 1'b0;

        // ---- reset during EXEC aborts the op ----
        issue(TLBOP_SRCH);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_done", 128'(op_if.done), 128'(0));
        chk("abort_ready", 128'(op_if.op_ready), 128'(1));
        issue(TLBOP_FILL);
        chk("abort_fill_idx", 128'(tlb_w_index), 128'(0));
        to_done(TLBOP_FILL);
        to_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Sequences the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB against the 16-entry TLB. It arbitrates TLB search port 1 between the load/store stage and maintenance ops. It generates the TLBFILL index from a free-running counter. It returns results to the CSR block through a one-cycle done pulse.

Parameters:
TLBNUM, 16, number of TLB entries.
IDXW, $clog2(TLBNUM), entry index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_valid  in  1  maintenance op request
op_ready  out  1  op accepted when op_valid && op_ready
op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, others reserved
inv_op  in  5  INVTLB op field
inv_asid  in  10  INVTLB rj ASID
inv_vppn  in  19  INVTLB rk VA[31:13]
csr_asid  in  10  ASID.asid
csr_vppn  in  19  TLBEHI.vppn
csr_index  in  IDXW  TLBIDX.index
csr_ps  in  6  TLBIDX.ps
csr_ne  in  1  TLBIDX.ne
csr_refill  in  1  ESTAT.ecode==0x3F
csr_elo0  in  27  TLBELO0 {ppn,g,mat,plv,d,v}
csr_elo1  in  27  TLBELO1 {ppn,g,mat,plv,d,v}
done  out  1  one-cycle op completion pulse
done_code  out  3  op_code of the completed op
res_found  out  1  SRCH hit
res_index  out  IDXW  SRCH hit index
res_ine  out  1  reserved op_code, or INV with inv_op>6
res_entry  out  TLBE_W  RD entry image
mem_req  in  1  load/store wants port 1
mem_vppn  in  19  load/store VA[31:13]
mem_bit12  in  1  load/store VA[12]
mem_asid  in  10  load/store ASID
mem_grant  out  1  port 1 serves load/store this cycle
tlb_s1_vppn  out  19  to TLB s1_vppn
tlb_s1_bit12  out  1  to TLB s1_va_bit12
tlb_s1_asid  out  10  to TLB s1_asid
tlb_s1_found  in  1  from TLB
tlb_s1_index  in  IDXW  from TLB
tlb_invtlb_valid  out  1  to TLB
tlb_invtlb_op  out  5  to TLB
tlb_we  out  1  to TLB
tlb_w_index  out  IDXW  to TLB
tlb_w_entry  out  TLBE_W  packed write entry
tlb_r_index  out  IDXW  to TLB
tlb_r_entry  in  TLBE_W  packed read entry

Behaviour:
- FSM states: IDLE, EXEC, DONE. Reset forces IDLE.
- op_ready = (state==IDLE).
- IDLE: on accept, latch op_code, inv fields, all csr_* inputs, and fill_idx = fill_cnt. Go to EXEC.
- EXEC lasts exactly 1 cycle, then DONE. DONE lasts exactly 1 cycle with done=1, then IDLE.
- Throughput is one op per 3 cycles. Accept in cycle 0 gives done in cycle 2.
- EXEC actions by op:
  - SRCH: port 1 driven with {csr_vppn, 0, csr_asid}. Capture res_found and res_index.
  - RD: tlb_r_index = csr_index. Capture tlb_r_entry into res_entry. If the entry has e=0, res_entry is zeros except e=0.
  - WR and FILL: tlb_we=1.
    - tlb_w_index = csr_index for WR, fill_idx for FILL.
    - w_e = csr_refill | ~csr_ne.
    - w_g = elo0.g & elo1.g.
    - w_vppn = csr_vppn; w_asid = csr_asid; w_ps = csr_ps.
  - INV: port 1 driven with {inv_vppn, 0, inv_asid}. tlb_invtlb_valid = (inv_op<=6), tlb_invtlb_op = inv_op. res_ine = (inv_op>6).
  - Reserved op_code: no TLB activity; res_ine=1.
- mem_grant = mem_req & ~(state==EXEC & op in {SRCH, INV}). When not granted, port 1 outputs carry the op's operands; otherwise they carry mem_*.
- fill_cnt is an IDXW-bit counter. It increments every cycle and wraps from TLBNUM-1 to 0.
- res_* registers hold until the next op's EXEC overwrites them. They are valid in the done cycle.
- Reset values:
  - All outputs 0.
  - mem_grant = mem_req, combinational.
  - fill_cnt = 0.
  - Reset during EXEC or DONE aborts the op: no done pulse, no further tlb_we. A write registered in the same cycle is not guaranteed.
- An op that follows WR or FILL sees the new entry: the TLB write lands at the end of EXEC, before the next op's EXEC.

Decomposition:
- Package tlb_pkg holds:
  - TLBOP_SRCH/RD/WR/FILL/INV constants.
  - ELO_W=27, TLBE_W=89.
  - Field offsets of the packed entry {e, vppn, ps, asid, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1}.
  - PS_4K=12, PS_4M=22.
- No sub-module is needed.

Test Plan:
- SRCH after WR of entry 5 (vppn 0x12345, asid 0x3, ps 12, ne=0) with TLBEHI=0x12345, ASID=0x3 -> done 2 cycles after accept, res_found=1, res_index=5.
- FILL accepted when fill_cnt=14; second FILL 3 cycles later -> writes land at index 14, then index 1 (wrap).
- INV op 5 asid 0x3 vppn 0x12345 while mem_req=1 -> mem_grant=0 only in the EXEC cycle; later SRCH misses (res_found=0).
- RD of an index with e=0 -> res_entry all zero; RD of entry 5 -> packed fields match the written values.
- INV with inv_op=7 and op_code=6 -> tlb_invtlb_valid stays 0, done with res_ine=1, TLB unchanged.
- Reset asserted in EXEC of a SRCH -> no done pulse, op_ready=1 the next cycle, fill_cnt=0.
